// File: rtl/uart_frame_ctrl.sv
// UART packet decoder feeding a double-buffered frame buffer.
// Handles pixel-write, clear and brightness packets with checksum, timeout and overrun reporting.
module uart_frame_ctrl #(
   parameter int unsigned PIXELS      = 64,
   parameter int unsigned TIMEOUT_CYC = 500000,
   parameter int unsigned AW          = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          fb_we,
   output logic [AW-1:0] fb_addr,
   output logic [7:0]    fb_wdata,
   output logic          frame_swap,
   output logic [7:0]    brightness,
   output logic          busy,
   output logic          err_cmd,
   output logic          err_len,
   output logic          err_chk,
   output logic          err_timeout,
   output logic          err_ovr
);

   localparam int unsigned CW   = $clog2(PIXELS + 1);
   localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [7:0]  SYNC = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_LEN, S_DATA, S_CHK, S_CLEAR
   } state_t;

   typedef enum logic [1:0] {
      OP_WRITE  = 2'd1,
      OP_CLEAR  = 2'd2,
      OP_BRIGHT = 2'd3
   } op_t;

   state_t          state_q, state_d;
   op_t             cmd_q, cmd_d;
   logic [7:0]      len_q, len_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [7:0]      chk_q, chk_d;
   logic [7:0]      shadow_q, shadow_d;
   logic            fb_we_d, frame_swap_d, busy_d;
   logic [AW-1:0]   fb_addr_d;
   logic [7:0]      fb_wdata_d, brightness_d;
   logic            err_cmd_d, err_len_d, err_chk_d, err_timeout_d, err_ovr_d;
   logic            len_ok;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cmd_q       <= OP_WRITE;
         len_q       <= '0;
         cnt_q       <= '0;
         tmo_q       <= '0;
         chk_q       <= '0;
         shadow_q    <= '0;
         fb_we       <= 1'b0;
         fb_addr     <= '0;
         fb_wdata    <= '0;
         frame_swap  <= 1'b0;
         brightness  <= 8'hFF;
         busy        <= 1'b0;
         err_cmd     <= 1'b0;
         err_len     <= 1'b0;
         err_chk     <= 1'b0;
         err_timeout <= 1'b0;
         err_ovr     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         chk_q       <= chk_d;
         shadow_q    <= shadow_d;
         fb_we       <= fb_we_d;
         fb_addr     <= fb_addr_d;
         fb_wdata    <= fb_wdata_d;
         frame_swap  <= frame_swap_d;
         brightness  <= brightness_d;
         busy        <= busy_d;
         err_cmd     <= err_cmd_d;
         err_len     <= err_len_d;
         err_chk     <= err_chk_d;
         err_timeout <= err_timeout_d;
         err_ovr     <= err_ovr_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d       = state_q;
      cmd_d         = cmd_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      tmo_d         = tmo_q;
      chk_d         = chk_q;
      shadow_d      = shadow_q;
      fb_we_d       = 1'b0;
      fb_addr_d     = fb_addr;
      fb_wdata_d    = fb_wdata;
      frame_swap_d  = 1'b0;
      brightness_d  = brightness;
      err_cmd_d     = 1'b0;
      err_len_d     = 1'b0;
      err_chk_d     = 1'b0;
      err_timeout_d = 1'b0;
      err_ovr_d     = 1'b0;
      len_ok        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (rx_valid && rx_data == SYNC) begin
               state_d = S_CMD;
               chk_d   = '0;
               tmo_d   = '0;
            end
         end
         S_CMD: begin
            if (rx_valid) begin
               if (rx_data == 8'h01 || rx_data == 8'h02 || rx_data == 8'h03) begin
                  cmd_d   = op_t'(rx_data[1:0]);
                  chk_d   = chk_q ^ rx_data;
                  state_d = S_LEN;
               end else begin
                  state_d   = S_IDLE;
                  err_cmd_d = 1'b1;
               end
            end
         end
         S_LEN: begin
            if (rx_valid) begin
               unique case (cmd_q)
                  OP_WRITE: len_ok = (rx_data != 8'd0) && (32'(rx_data) <= PIXELS);
                  OP_CLEAR: len_ok = (rx_data == 8'd0);
                  default:  len_ok = (rx_data == 8'd1);
               endcase
               chk_d = chk_q ^ rx_data;
               len_d = rx_data;
               if (!len_ok) begin
                  state_d   = S_IDLE;
                  err_len_d = 1'b1;
               end else if (rx_data == 8'd0) begin
                  state_d = S_CHK;
               end else begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end
            end
         end
         S_DATA: begin
            if (rx_valid) begin
               chk_d = chk_q ^ rx_data;
               cnt_d = cnt_q + CW'(1);
               if (cmd_q == OP_WRITE) begin
                  fb_we_d    = 1'b1;
                  fb_addr_d  = AW'(cnt_q);
                  fb_wdata_d = rx_data;
               end else begin
                  shadow_d = rx_data;
               end
               if (cnt_q == CW'(len_q - 8'd1)) state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (rx_valid) begin
               state_d = S_IDLE;
               if (rx_data == chk_q) begin
                  unique case (cmd_q)
                     OP_WRITE: frame_swap_d = 1'b1;
                     OP_CLEAR: begin
                        state_d = S_CLEAR;
                        cnt_d   = '0;
                     end
                     default:  brightness_d = shadow_q;
                  endcase
               end else begin
                  err_chk_d = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            // Bytes arriving during the sweep are dropped and flagged
            err_ovr_d = rx_valid;
            if (cnt_q == CW'(PIXELS)) begin
               frame_swap_d = 1'b1;
               state_d      = S_IDLE;
               cnt_d        = '0;
            end else begin
               fb_we_d    = 1'b1;
               fb_addr_d  = AW'(cnt_q);
               fb_wdata_d = 8'd0;
               cnt_d      = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Inter-byte watchdog; a byte on the expiry cycle wins
      if (state_q inside {S_CMD, S_LEN, S_DATA, S_CHK}) begin
         if (rx_valid) begin
            tmo_d = '0;
         end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d       = S_IDLE;
            err_timeout_d = 1'b1;
            tmo_d         = '0;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end

      busy_d = (state_d != S_IDLE);
   end

endmodule
